// File: rtl/cmd_dispatch_p.sv
// Host command dispatcher: decodes 24-bit UART commands into SPI transactions,
// tracks per-channel gain settings and returns ACK/NAK/read-data responses.
module cmd_dispatch_p #(
    parameter int          NUM_CH  = 3,
    parameter logic [7:0]  GAIN_HI = 8'h13,
    parameter int          TIMEOUT = 1024,
    parameter logic [7:0]  ACK     = 8'hA5,
    parameter logic [7:0]  NAK     = 8'hEE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_rdy,
    input  logic [23:0]           cmd,
    output logic                  clr_cmd_rdy,
    output logic                  wrt_SPI,
    output logic [15:0]           SPI_data,
    output logic [2:0]            ss,
    input  logic                  SPI_done,
    input  logic [7:0]            EEP_rd_data,
    output logic                  send_resp,
    output logic [7:0]            resp_data,
    input  logic                  resp_sent,
    output logic [3*NUM_CH-1:0]   gain,
    output logic [NUM_CH-1:0]     capture_gain
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, SPI_WAIT, RD_GAP, RD_WAIT, RESP, RESP_WAIT} state_t;
    typedef enum logic [3:0] {
        OP_CFG_GAIN = 4'h2,
        OP_SET_TRIG = 4'h3,
        OP_RD_GAIN  = 4'h4,
        OP_WRT_EEP  = 4'h8,
        OP_RD_EEP   = 4'h9
    } op_t;

    state_t            state;
    logic [23:0]       cmd_q;
    logic [WD_W-1:0]   wd;
    logic [7:0]        gain_code;
    logic              ch_ok;
    logic [2:0]        rd_gain;
    logic              wd_expired;

    always_comb begin
        case (cmd[12:10])
            3'd0:    gain_code = 8'h02;
            3'd1:    gain_code = 8'h05;
            3'd2:    gain_code = 8'h09;
            3'd3:    gain_code = 8'h14;
            3'd4:    gain_code = 8'h28;
            3'd5:    gain_code = 8'h46;
            3'd6:    gain_code = 8'h6B;
            default: gain_code = 8'hDD;
        endcase
    end

    always_comb begin
        ch_ok   = 1'b0;
        rd_gain = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (i == 32'(cmd[9:8])) begin
                ch_ok   = 1'b1;
                rd_gain = gain[3*i +: 3];
            end
        end
    end

    assign wd_expired = (wd == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cmd_q        <= '0;
            wd           <= '0;
            clr_cmd_rdy  <= 1'b0;
            wrt_SPI      <= 1'b0;
            SPI_data     <= '0;
            ss           <= '0;
            send_resp    <= 1'b0;
            resp_data    <= '0;
            gain         <= '0;
            capture_gain <= '0;
        end else begin
            clr_cmd_rdy  <= 1'b0;
            wrt_SPI      <= 1'b0;
            send_resp    <= 1'b0;
            capture_gain <= '0;
            case (state)
                IDLE: begin
                    if (cmd_rdy) begin
                        cmd_q       <= cmd;
                        clr_cmd_rdy <= 1'b1;
                        wd          <= '0;
                        case (cmd[19:16])
                            OP_CFG_GAIN: begin
                                if (ch_ok) begin
                                    SPI_data <= {GAIN_HI, gain_code};
                                    ss       <= 3'(cmd[9:8]) + 3'd1;
                                    wrt_SPI  <= 1'b1;
                                    state    <= SPI_WAIT;
                                end else begin
                                    resp_data <= NAK;
                                    state     <= RESP;
                                end
                            end
                            OP_SET_TRIG: begin
                                SPI_data <= {8'h00, cmd[7:0]};
                                ss       <= 3'd7;
                                wrt_SPI  <= 1'b1;
                                state    <= SPI_WAIT;
                            end
                            OP_RD_GAIN: begin
                                resp_data <= ch_ok ? {5'b0, rd_gain} : NAK;
                                state     <= RESP;
                            end
                            OP_WRT_EEP: begin
                                SPI_data <= {2'b01, cmd[13:0]};
                                ss       <= 3'd4;
                                wrt_SPI  <= 1'b1;
                                state    <= SPI_WAIT;
                            end
                            OP_RD_EEP: begin
                                SPI_data <= {2'b00, cmd[13:8], 8'h00};
                                ss       <= 3'd4;
                                wrt_SPI  <= 1'b1;
                                state    <= SPI_WAIT;
                            end
                            default: begin
                                resp_data <= NAK;
                                state     <= RESP;
                            end
                        endcase
                    end
                end
                SPI_WAIT: begin
                    // SPI_done is checked first so it wins over a same-edge watchdog expiry
                    if (SPI_done) begin
                        case (cmd_q[19:16])
                            OP_RD_EEP: state <= RD_GAP;
                            OP_CFG_GAIN: begin
                                for (int unsigned i = 0; i < NUM_CH; i++) begin
                                    if (i == 32'(cmd_q[9:8])) begin
                                        gain[3*i +: 3]  <= cmd_q[12:10];
                                        capture_gain[i] <= 1'b1;
                                    end
                                end
                                resp_data <= ACK;
                                ss        <= '0;
                                state     <= RESP;
                            end
                            default: begin
                                resp_data <= ACK;
                                ss        <= '0;
                                state     <= RESP;
                            end
                        endcase
                    end else if (wd_expired) begin
                        resp_data <= NAK;
                        ss        <= '0;
                        state     <= RESP;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                RD_GAP: begin
                    wrt_SPI <= 1'b1;
                    wd      <= '0;
                    state   <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (SPI_done) begin
                        resp_data <= EEP_rd_data;
                        ss        <= '0;
                        state     <= RESP;
                    end else if (wd_expired) begin
                        resp_data <= NAK;
                        ss        <= '0;
                        state     <= RESP;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                RESP: begin
                    send_resp <= 1'b1;
                    state     <= RESP_WAIT;
                end
                RESP_WAIT: begin
                    if (resp_sent) begin
                        SPI_data <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_dispatch_p.sv
// Self-checking bench for cmd_dispatch_p: vector table for single commands,
// response scoreboard, plus hand-written timeout and reset-abort sequences.
module tb_cmd_dispatch_p;

    localparam int NUM_CH  = 2;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_rdy = 1'b0;
    logic [23:0] cmd = '0;
    logic        clr_cmd_rdy;
    logic        wrt_SPI;
    logic [15:0] SPI_data;
    logic [2:0]  ss;
    logic        SPI_done = 1'b0;
    logic [7:0]  EEP_rd_data = '0;
    logic        send_resp;
    logic [7:0]  resp_data;
    logic        resp_sent = 1'b0;
    logic [3*NUM_CH-1:0] gain;
    logic [NUM_CH-1:0]   capture_gain;

    int checks = 0;
    int passes = 0;
    logic [7:0] resp_q[$];

    cmd_dispatch_p #(.NUM_CH(NUM_CH), .GAIN_HI(8'h13), .TIMEOUT(TIMEOUT),
                     .ACK(8'hA5), .NAK(8'hEE)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_rdy(cmd_rdy), .cmd(cmd),
        .clr_cmd_rdy(clr_cmd_rdy), .wrt_SPI(wrt_SPI), .SPI_data(SPI_data),
        .ss(ss), .SPI_done(SPI_done), .EEP_rd_data(EEP_rd_data),
        .send_resp(send_resp), .resp_data(resp_data), .resp_sent(resp_sent),
        .gain(gain), .capture_gain(capture_gain)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0h want %0h", name, act, exp);
        else passes++;
    endtask

    always @(negedge clk) begin
        if (rst_n && send_resp) begin
            if (resp_q.size() == 0) chk("unexpected_resp", 32'(resp_data), 32'hFFFF);
            else chk("resp_data", 32'(resp_data), 32'(resp_q.pop_front()));
        end
    end

    typedef struct {
        logic [23:0] cmd;
        bit          spi;
        bit          rd;
        logic [15:0] data;
        logic [2:0]  ss;
        logic [7:0]  eep;
        logic [7:0]  resp;
        logic [1:0]  cap;
        logic [5:0]  gain;
    } vec_t;

    vec_t vecs[12];

    task automatic finish_resp();
        @(negedge clk);
        chk("send_resp_timing", 32'(send_resp), 1);
        resp_sent = 1'b1;
        @(negedge clk);
        resp_sent = 1'b0;
        chk("idle_ss", 32'(ss), 0);
        chk("idle_spi_data", 32'(SPI_data), 0);
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        cmd = v.cmd;
        cmd_rdy = 1'b1;
        resp_q.push_back(v.resp);
        @(negedge clk);
        cmd_rdy = 1'b0;
        chk("clr_cmd_rdy", 32'(clr_cmd_rdy), 1);
        chk("wrt_SPI", 32'(wrt_SPI), 32'(v.spi));
        chk("SPI_data", 32'(SPI_data), 32'(v.data));
        chk("ss", 32'(ss), 32'(v.ss));
        if (v.spi) begin
            repeat (2) begin
                @(negedge clk);
                chk("ss_hold", 32'(ss), 32'(v.ss));
                chk("wrt_SPI_idle", 32'(wrt_SPI), 0);
            end
            SPI_done = 1'b1;
            @(negedge clk);
            SPI_done = 1'b0;
            if (v.rd) begin
                chk("rd_gap_ss", 32'(ss), 4);
                @(negedge clk);
                chk("rd_wrt2", 32'(wrt_SPI), 1);
                chk("rd_data2", 32'(SPI_data), 32'(v.data));
                @(negedge clk);
                EEP_rd_data = v.eep;
                SPI_done = 1'b1;
                @(negedge clk);
                SPI_done = 1'b0;
                chk("rd_resp_ss", 32'(ss), 0);
            end else begin
                chk("capture_gain", 32'(capture_gain), 32'(v.cap));
            end
        end
        chk("gain", 32'(gain), 32'(v.gain));
        finish_resp();
    endtask

    initial begin
        vecs[0]  = '{24'h021C00, 1'b1, 1'b0, 16'h13DD, 3'd1, 8'h00, 8'hA5, 2'b01, 6'o07};
        vecs[1]  = '{24'h020B00, 1'b0, 1'b0, 16'h0000, 3'd0, 8'h00, 8'hEE, 2'b00, 6'o07};
        vecs[2]  = '{24'h040100, 1'b0, 1'b0, 16'h0000, 3'd0, 8'h00, 8'h00, 2'b00, 6'o07};
        vecs[3]  = '{24'h040000, 1'b0, 1'b0, 16'h0000, 3'd0, 8'h00, 8'h07, 2'b00, 6'o07};
        vecs[4]  = '{24'h031CEF, 1'b1, 1'b0, 16'h00EF, 3'd7, 8'h00, 8'hA5, 2'b00, 6'o07};
        vecs[5]  = '{24'h092CBF, 1'b1, 1'b1, 16'h2C00, 3'd4, 8'h5A, 8'h5A, 2'b00, 6'o07};
        vecs[6]  = '{24'h021100, 1'b1, 1'b0, 16'h1328, 3'd2, 8'h00, 8'hA5, 2'b10, 6'o47};
        vecs[7]  = '{24'h020600, 1'b0, 1'b0, 16'h0000, 3'd0, 8'h00, 8'hEE, 2'b00, 6'o47};
        vecs[8]  = '{24'h040200, 1'b0, 1'b0, 16'h0000, 3'd0, 8'h00, 8'hEE, 2'b00, 6'o47};
        vecs[9]  = '{24'h050000, 1'b0, 1'b0, 16'h0000, 3'd0, 8'h00, 8'hEE, 2'b00, 6'o47};
        vecs[10] = '{24'h0812AB, 1'b1, 1'b0, 16'h52AB, 3'd4, 8'h00, 8'hA5, 2'b00, 6'o47};
        vecs[11] = '{24'h040100, 1'b0, 1'b0, 16'h0000, 3'd0, 8'h00, 8'h04, 2'b00, 6'o47};

        repeat (3) @(negedge clk);
        chk("rst_clr", 32'(clr_cmd_rdy), 0);
        chk("rst_wrt", 32'(wrt_SPI), 0);
        chk("rst_spi_data", 32'(SPI_data), 0);
        chk("rst_ss", 32'(ss), 0);
        chk("rst_send", 32'(send_resp), 0);
        chk("rst_resp", 32'(resp_data), 0);
        chk("rst_gain", 32'(gain), 0);
        chk("rst_cap", 32'(capture_gain), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Watchdog: WRT_EEP with no SPI_done; a queued command must wait for resp_sent
        @(negedge clk);
        cmd = 24'h081CEF;
        cmd_rdy = 1'b1;
        resp_q.push_back(8'hEE);
        @(negedge clk);
        chk("to_wrt", 32'(wrt_SPI), 1);
        chk("to_data", 32'(SPI_data), 32'h5CEF);
        cmd = 24'h040000;
        resp_q.push_back(8'h07);
        for (int j = 0; j < TIMEOUT - 1; j++) begin
            @(negedge clk);
            chk("to_ss_hold", 32'(ss), 4);
            chk("to_no_accept", 32'(clr_cmd_rdy), 0);
        end
        @(negedge clk);
        chk("to_ss_zero", 32'(ss), 0);
        chk("to_no_send_yet", 32'(send_resp), 0);
        @(negedge clk);
        chk("to_send", 32'(send_resp), 1);
        chk("to_busy", 32'(clr_cmd_rdy), 0);
        resp_sent = 1'b1;
        @(negedge clk);
        resp_sent = 1'b0;
        chk("to_still_busy", 32'(clr_cmd_rdy), 0);
        @(negedge clk);
        chk("to_accept", 32'(clr_cmd_rdy), 1);
        cmd_rdy = 1'b0;
        finish_resp();

        // Reset in SPI_WAIT of CFG_GAIN ch1, ggg=3
        @(negedge clk);
        cmd = 24'h020D00;
        cmd_rdy = 1'b1;
        @(negedge clk);
        cmd_rdy = 1'b0;
        chk("ra_wrt", 32'(wrt_SPI), 1);
        chk("ra_data", 32'(SPI_data), 32'h1314);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("ra_ss", 32'(ss), 0);
        chk("ra_spi_data", 32'(SPI_data), 0);
        chk("ra_gain", 32'(gain), 0);
        chk("ra_resp", 32'(resp_data), 0);
        SPI_done = 1'b1;
        @(negedge clk);
        SPI_done = 1'b0;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("ra_no_send", 32'(send_resp), 0);
            chk("ra_no_cap", 32'(capture_gain), 0);
        end
        chk("ra_gain_after", 32'(gain), 0);
        chk("queue_empty", 32'(resp_q.size()), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
